// File: rtl/rtl_utils_pkg.sv
// Shared definitions for small utility blocks (debounce, synchronisers).
//
// Contents:
//   deb_state_e      - debounce FSM state encoding
//   SYNC_STAGES_MIN  - smallest legal synchroniser depth
//   SYNC_STAGES_MAX  - largest legal synchroniser depth
//   stable_state()   - maps a settled level to its STABLE_* state
package rtl_utils_pkg;

    // The encodings are fixed so that a waveform or a debug readout of the
    // state can be decoded without the source at hand.
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } deb_state_e;

    // Fewer than two flops gives no metastability protection. More than
    // four only adds latency without a useful MTBF gain at our clock rates.
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Resting state that corresponds to a settled level.
    function automatic deb_state_e stable_state(input logic lvl);
        return lvl ? ST_STABLE_HI : ST_STABLE_LO;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (2..4)
//   RST_VAL     - level loaded into every flop on reset
//
// Ports:
//   clk   - destination clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output (last flop of the chain)
module sync_ff
    import rtl_utils_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_ff: SYNC_STAGES must be within 2..4");
    end

    // Bit 0 is the flop that samples d; the top bit feeds q.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchroniser plus debouncer for a raw asynchronous input (button, switch,
// external strobe). The input is synchronised free-running on every clk. A
// level change is then accepted only after it has stayed stable for
// DEBOUNCE_CYCLES ce-qualified cycles. A change that reverts before that is
// discarded and counted as a glitch.
//
// Parameters:
//   SYNC_STAGES     - synchroniser depth (2..4)
//   DEBOUNCE_CYCLES - ce-qualified stable cycles needed to accept a change (>= 1)
//   RST_VAL         - reset level of the synchroniser, FSM state and sig_out
//   GLITCH_W        - width of the saturating glitch counter
//
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   ce         - clock enable for the FSM and glitch counting
//   sig_in     - raw asynchronous input
//   glitch_clr - synchronous clear of glitch_cnt; acts regardless of ce
//   sig_out    - debounced level (registered)
//   settling   - high while a level change is being qualified
//   glitch_cnt - saturating count of aborted transitions
module debounce_sync
    import rtl_utils_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          RST_VAL         = 1'b0,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                sig_in,
    input  logic                glitch_clr,
    output logic                sig_out,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("debounce_sync: SYNC_STAGES must be within 2..4");
    end

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be at least 1");
    end

    // The dwell counter counts from 0 up to DEBOUNCE_CYCLES-1 and never
    // higher. The +1 in the width keeps DEBOUNCE_CYCLES=1 at one bit.
    localparam int unsigned         CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic s;

    deb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sig_out_q, sig_out_d;
    logic                glitch_evt;
    logic [GLITCH_W-1:0] glitch_q;

    // ------------------------------------------------------------------
    // Synchroniser. It runs on every clk, so the FSM always sees an input
    // that is up to date, even after a long ce-low stretch.
    // ------------------------------------------------------------------
    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (s)
    );

    // ------------------------------------------------------------------
    // FSM state register. State, the dwell counter and sig_out all hold on
    // clk edges where ce is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= stable_state(RST_VAL);
            cnt_q     <= '0;
            sig_out_q <= RST_VAL;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sig_out_q <= sig_out_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. sig_out only changes when a WAIT state
    // completes. An abort leaves sig_out at its old value and raises
    // glitch_evt.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sig_out_d  = sig_out_q;
        glitch_evt = 1'b0;

        unique case (state_q)
            ST_STABLE_LO: begin
                if (s) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_HI: begin
                if (!s) begin
                    state_d    = ST_STABLE_LO;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE_HI;
                    sig_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STABLE_HI: begin
                if (!s) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_LO: begin
                if (s) begin
                    state_d    = ST_STABLE_HI;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE_LO;
                    sig_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = stable_state(sig_out_q);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs.
    // ------------------------------------------------------------------
    always_comb begin
        settling = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
        sig_out  = sig_out_q;
    end

    // ------------------------------------------------------------------
    // Glitch counter. A clear overrides an increment on the same edge, and
    // the count sticks at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (glitch_clr) begin
            glitch_q <= '0;
        end else if (ce && glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_q <= glitch_q + 1'b1;
        end
    end

    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=8.
// Instance u_dut_a uses RST_VAL=0 and u_dut_b uses RST_VAL=1.
// For each stimulus change the bench works out, from the input-to-output
// latency rules, which clk edge each output is due to show a given value.
// It pushes that (edge, signal, value) onto a scoreboard. A monitor runs on
// every falling edge and pops and compares the entries that fall due.
module tb_debounce_sync;

    localparam int SEL_OUT_A = 0;
    localparam int SEL_SET_A = 1;
    localparam int SEL_GC_A  = 2;
    localparam int SEL_OUT_B = 3;
    localparam int SEL_SET_B = 4;
    localparam int SEL_GC_B  = 5;

    typedef struct {
        int    due;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    logic       clk;
    logic       rst_n, ce, sig_in, glitch_clr;
    logic       sig_out, settling;
    logic [7:0] glitch_cnt;
    logic       rst_n_b, ce_b, sig_in_b, glitch_clr_b;
    logic       sig_out_b, settling_b;
    logic [7:0] glitch_cnt_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RST_VAL         (1'b0),
        .GLITCH_W        (8)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .sig_in     (sig_in),
        .glitch_clr (glitch_clr),
        .sig_out    (sig_out),
        .settling   (settling),
        .glitch_cnt (glitch_cnt)
    );

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RST_VAL         (1'b1),
        .GLITCH_W        (8)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .ce         (ce_b),
        .sig_in     (sig_in_b),
        .glitch_clr (glitch_clr_b),
        .sig_out    (sig_out_b),
        .settling   (settling_b),
        .glitch_cnt (glitch_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_OUT_A: return int'(sig_out);
            SEL_SET_A: return int'(settling);
            SEL_GC_A:  return int'(glitch_cnt);
            SEL_OUT_B: return int'(sig_out_b);
            SEL_SET_B: return int'(settling_b);
            default:   return int'(glitch_cnt_b);
        endcase
    endfunction

    // Expect signal sel to equal val after the edge 'offset' edges from now.
    task automatic expect_at(input string tag, input int offset, input int sel, input int val);
        exp_t e;
        e.due = cyc + offset;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two clk high, two clk low. The aborted WAIT_HI lands 5 edges after the start.
    task automatic bounce();
        sig_in = 1'b1;
        step(2);
        sig_in = 1'b0;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; sig_in = 1'b0; glitch_clr = 1'b0;
        rst_n_b = 1'b0; ce_b = 1'b1; sig_in_b = 1'b1; glitch_clr_b = 1'b0;
        step(2);

        // Reset state of both instances.
        expect_at("rst_a_out", 1, SEL_OUT_A, 0);
        expect_at("rst_a_set", 1, SEL_SET_A, 0);
        expect_at("rst_a_gc",  1, SEL_GC_A,  0);
        expect_at("rst_b_out", 1, SEL_OUT_B, 1);
        expect_at("rst_b_set", 1, SEL_SET_B, 0);
        expect_at("rst_b_gc",  1, SEL_GC_B,  0);
        step(1);
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        step(2);

        // 1. Basic rise: sig_out rises after the 7th edge.
        sig_in = 1'b1;
        expect_at("rise_out_e1", 1, SEL_OUT_A, 0);
        expect_at("rise_set_e2", 2, SEL_SET_A, 0);
        expect_at("rise_set_e3", 3, SEL_SET_A, 1);
        expect_at("rise_set_e6", 6, SEL_SET_A, 1);
        expect_at("rise_out_e6", 6, SEL_OUT_A, 0);
        expect_at("rise_out_e7", 7, SEL_OUT_A, 1);
        expect_at("rise_set_e7", 7, SEL_SET_A, 0);
        expect_at("rise_gc_e7",  7, SEL_GC_A,  0);
        step(10);

        // Fall back low.
        sig_in = 1'b0;
        expect_at("fall_out_e6", 6, SEL_OUT_A, 1);
        expect_at("fall_out_e7", 7, SEL_OUT_A, 0);
        step(10);

        // 2. Bounce, then a clean rise.
        sig_in = 1'b1;
        expect_at("bnc_set_e3", 3, SEL_SET_A, 1);
        expect_at("bnc_gc_e4",  4, SEL_GC_A,  0);
        expect_at("bnc_gc_e5",  5, SEL_GC_A,  1);
        expect_at("bnc_set_e5", 5, SEL_SET_A, 0);
        expect_at("bnc_out_e7", 7, SEL_OUT_A, 0);
        step(2);
        sig_in = 1'b0;
        step(6);
        sig_in = 1'b1;
        expect_at("bnc_rise_out_e6", 6, SEL_OUT_A, 0);
        expect_at("bnc_rise_out_e7", 7, SEL_OUT_A, 1);
        expect_at("bnc_rise_gc_e7",  7, SEL_GC_A,  1);
        step(10);
        sig_in = 1'b0;
        expect_at("bnc_fall_out_e7", 7, SEL_OUT_A, 0);
        step(10);

        // 3. ce high on every other edge. WAIT_HI spans 4 ce cycles = 8 clk.
        sig_in = 1'b1;
        ce = 1'b0;
        expect_at("ce_set_e3",  3,  SEL_SET_A, 0);
        expect_at("ce_set_e4",  4,  SEL_SET_A, 1);
        expect_at("ce_set_e11", 11, SEL_SET_A, 1);
        expect_at("ce_out_e11", 11, SEL_OUT_A, 0);
        expect_at("ce_out_e12", 12, SEL_OUT_A, 1);
        expect_at("ce_set_e12", 12, SEL_SET_A, 0);
        for (int i = 0; i < 16; i++) begin
            step(1);
            ce = ~ce;
        end
        ce = 1'b1;
        step(2);

        // 5. Reset in WAIT_HI with cnt=2 discards the pending rise.
        rst_n = 1'b0;
        sig_in = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        sig_in = 1'b1;
        expect_at("rmw_set_e5", 5, SEL_SET_A, 1);
        step(5);
        rst_n = 1'b0;
        expect_at("rmw_out_rst", 1, SEL_OUT_A, 0);
        expect_at("rmw_set_rst", 1, SEL_SET_A, 0);
        expect_at("rmw_gc_rst",  1, SEL_GC_A,  0);
        step(1);
        rst_n = 1'b1;
        expect_at("rmw_set_e3", 3, SEL_SET_A, 1);
        expect_at("rmw_out_e6", 6, SEL_OUT_A, 0);
        expect_at("rmw_out_e7", 7, SEL_OUT_A, 1);
        step(10);

        // 4. Saturation, then a clear on the same edge as a glitch event.
        rst_n = 1'b0;
        sig_in = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        for (int i = 1; i <= 300; i++) begin
            bounce();
            if (i == 200) expect_at("sat_gc_200", 1, SEL_GC_A, 200);
        end
        expect_at("sat_gc_300", 2, SEL_GC_A, 255);
        expect_at("clr_gc_e4",  4, SEL_GC_A, 255);
        expect_at("clr_set_e4", 4, SEL_SET_A, 1);
        expect_at("clr_set_e5", 5, SEL_SET_A, 0);
        expect_at("clr_gc_e5",  5, SEL_GC_A, 0);
        bounce();
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        step(1);
        expect_at("post_clr_gc", 5, SEL_GC_A, 1);
        bounce();
        step(4);

        // 6. RST_VAL=1 instance: fall, rise, then a fall with a glitch in WAIT_LO.
        sig_in_b = 1'b0;
        expect_at("b_fall_set_e3", 3, SEL_SET_B, 1);
        expect_at("b_fall_out_e6", 6, SEL_OUT_B, 1);
        expect_at("b_fall_out_e7", 7, SEL_OUT_B, 0);
        step(10);
        sig_in_b = 1'b1;
        expect_at("b_rise_out_e7", 7, SEL_OUT_B, 1);
        step(10);
        sig_in_b = 1'b0;
        expect_at("b_gl_set_e4",  4,  SEL_SET_B, 1);
        expect_at("b_gl_gc_e4",   4,  SEL_GC_B,  0);
        expect_at("b_gl_gc_e5",   5,  SEL_GC_B,  1);
        expect_at("b_gl_set_e5",  5,  SEL_SET_B, 0);
        expect_at("b_gl_set_e6",  6,  SEL_SET_B, 1);
        expect_at("b_gl_out_e7",  7,  SEL_OUT_B, 1);
        expect_at("b_gl_out_e9",  9,  SEL_OUT_B, 1);
        expect_at("b_gl_out_e10", 10, SEL_OUT_B, 0);
        step(2);
        sig_in_b = 1'b1;
        step(1);
        sig_in_b = 1'b0;
        step(12);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
        while (sb.size() != 0) begin
            check({sb[0].tag, "_timeout"}, -1, sb[0].val);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
